// File: rtl/clk_mux_gen_if.sv
// Button-in / step-clock-out bundle between the board I/O and the LED step clock generator.
interface clk_mux_gen_if;
  logic       KEY_N;
  logic       CLK_MUX;
  logic [1:0] SPEED;
  logic       STEP;

  modport master (output KEY_N, input CLK_MUX, input SPEED, input STEP);
  modport slave  (input KEY_N, output CLK_MUX, output SPEED, output STEP);
endinterface

// File: rtl/clk_mux_gen.sv
// Slow step clock for the LED rotator: a debounced button cycles four divide rates,
// and every output is a flop so CLK_MUX stays glitch-free.
module clk_mux_gen #(
  parameter int CNT_W        = 26,
  parameter int DIV0         = 25_000_000,
  parameter int DIV1         = 12_500_000,
  parameter int DIV2         = 6_250_000,
  parameter int DIV3         = 2_500_000,
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic          CLK,
  input  logic          RST_N,
  clk_mux_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] HALF0_LAST = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] HALF1_LAST = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] HALF2_LAST = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] HALF3_LAST = CNT_W'(DIV3 - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic             key_p0;
  logic             key_p1;
  logic             key_s;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] dvcnt;
  logic [CNT_W-1:0] half_last;
  logic [1:0]       speed;
  logic             clk_mux;
  logic             step;
  logic             press;

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= bus.KEY_N;
      key_p1 <= key_p0;
    end
  end

  assign key_s = key_p1;

  // Stage p2: debounce FSM; a bounce during release drops back to PRESSED without a new event
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s)                state <= IDLE;
          else if (dcnt == DB_LAST) state <= PRESSED;
          else                      dcnt  <= dcnt + CNT_W'(1);
        end
        PRESSED: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s)               state <= PRESSED;
          else if (dcnt == DB_LAST) state <= IDLE;
          else                      dcnt  <= dcnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press = (state == PRESS_WAIT) && !key_s && (dcnt == DB_LAST);

  always_comb begin
    half_last = HALF0_LAST;
    case (speed)
      2'd0: half_last = HALF0_LAST;
      2'd1: half_last = HALF1_LAST;
      2'd2: half_last = HALF2_LAST;
      2'd3: half_last = HALF3_LAST;
      default: half_last = HALF0_LAST;
    endcase
  end

  // Stage p3: rate select and divider; >= keeps the count bounded even if the half-period shrinks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      speed   <= 2'd0;
      dvcnt   <= '0;
      clk_mux <= 1'b0;
      step    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (press) begin
        speed <= speed + 2'd1;
        dvcnt <= '0;
      end else if (dvcnt >= half_last) begin
        dvcnt   <= '0;
        clk_mux <= ~clk_mux;
        step    <= ~clk_mux;
      end else begin
        dvcnt <= dvcnt + CNT_W'(1);
      end
    end
  end

  assign bus.CLK_MUX = clk_mux;
  assign bus.SPEED   = speed;
  assign bus.STEP    = step;

endmodule

// File: tb/tb_clk_mux_gen.sv
// Self-checking bench for clk_mux_gen: run-length reference model, pulse table and hand sequences.
module tb_clk_mux_gen;

  localparam int DIV0 = 4;
  localparam int DIV1 = 3;
  localparam int DIV2 = 2;
  localparam int DIV3 = 1;
  localparam int DB   = 5;

  logic CLK;
  logic RST_N;

  clk_mux_gen_if bus ();

  clk_mux_gen #(
    .CNT_W(8), .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .DEBOUNCE_CNT(DB)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: press = low run of D+1 synchronized samples while armed,
  // re-arm = high run of D+1 samples; divider counts edges since last restart.
  logic ksq[$];
  bit   m_armed;
  int   m_low_run, m_high_run;
  int   m_speed, m_cnt;
  bit   m_clk, m_step;
  int   div_tab[4] = '{DIV0, DIV1, DIV2, DIV3};

  task automatic model_reset();
    ksq = {};
    ksq.push_back(1'b1);
    ksq.push_back(1'b1);
    m_armed = 1; m_low_run = 0; m_high_run = 0;
    m_speed = 0; m_cnt = 0; m_clk = 0; m_step = 0;
  endtask

  task automatic model_edge(input logic key_now);
    logic ks;
    bit   press;
    ks = ksq.pop_front();
    ksq.push_back(key_now);
    press = 0;
    if (ks == 1'b0) begin m_low_run++; m_high_run = 0; end
    else            begin m_high_run++; m_low_run = 0; end
    if (m_armed && m_low_run == DB + 1) begin
      press = 1; m_armed = 0;
    end else if (!m_armed && m_high_run == DB + 1) begin
      m_armed = 1;
    end
    m_step = 0;
    if (press) begin
      m_speed = (m_speed + 1) % 4;
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt >= div_tab[m_speed]) begin
        m_clk = !m_clk;
        m_cnt = 0;
        m_step = m_clk;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Called just after a posedge (or a negedge); drives KEY_N, clocks once, checks against the model.
  task automatic step_cyc(input logic key);
    bus.KEY_N = key;
    @(posedge CLK);
    cyc++;
    model_edge(key);
    #1;
    chk("model_clk_mux", {31'd0, bus.CLK_MUX}, {31'd0, m_clk});
    chk("model_speed",   {30'd0, bus.SPEED},   m_speed);
    chk("model_step",    {31'd0, bus.STEP},    {31'd0, m_step});
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    bus.KEY_N = 1'b1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_clk_mux", {31'd0, bus.CLK_MUX}, 0);
    chk("rst_speed",   {30'd0, bus.SPEED},   0);
    chk("rst_step",    {31'd0, bus.STEP},    0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0;
  endtask

  task automatic pulse(input int lo, input int hi);
    for (int i = 0; i < lo; i++) step_cyc(1'b0);
    for (int i = 0; i < hi; i++) step_cyc(1'b1);
  endtask

  typedef struct {
    int l1, h1, l2, h2;
    int inc;
  } vec_t;

  vec_t tab[11];
  int   exp_speed;
  bit   found;
  int   rise_e;

  initial begin
    tab[0]  = '{3,  10, 0, 0,  0};
    tab[1]  = '{5,  10, 0, 0,  0};
    tab[2]  = '{6,  10, 0, 0,  1};
    tab[3]  = '{3,  2,  4, 10, 0};
    tab[4]  = '{10, 10, 0, 0,  1};
    tab[5]  = '{10, 2,  3, 12, 1};
    tab[6]  = '{7,  10, 0, 0,  1};
    tab[7]  = '{40, 10, 0, 0,  1};
    tab[8]  = '{10, 10, 0, 0,  1};
    tab[9]  = '{10, 10, 0, 0,  1};
    tab[10] = '{10, 10, 0, 0,  1};

    RST_N = 1'b0;
    bus.KEY_N = 1'b1;

    // Reset and idle: period 8, STEP on each rise
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step_cyc(1'b1);
      chk($sformatf("idle_clk_e%0d", e),  {31'd0, bus.CLK_MUX}, (e / 4) % 2);
      chk($sformatf("idle_step_e%0d", e), {31'd0, bus.STEP},    (e % 8 == 4) ? 1 : 0);
    end

    // Clean press held from edge 1: SPEED changes on edge DB+3, CLK_MUX holds, then period 6
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step_cyc(1'b0);
      chk($sformatf("press_speed_e%0d", e), {30'd0, bus.SPEED}, (e >= 8) ? 1 : 0);
      if (e < 8)
        chk($sformatf("press_clk_e%0d", e), {31'd0, bus.CLK_MUX}, (e / 4) % 2);
      else
        chk($sformatf("press_clk_e%0d", e), {31'd0, bus.CLK_MUX}, 1 ^ (((e - 8) / 3) % 2));
      chk($sformatf("press_step_e%0d", e), {31'd0, bus.STEP},
          ((e == 4) || (e > 8 && (e - 8) % 6 == 0)) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) step_cyc(1'b1);

    // Pulse table: glitches, bounces, release bounce and wrap-around
    do_reset();
    for (int i = 0; i < 10; i++) step_cyc(1'b1);
    exp_speed = 0;
    foreach (tab[k]) begin
      pulse(tab[k].l1, tab[k].h1);
      pulse(tab[k].l2, tab[k].h2);
      exp_speed = (exp_speed + tab[k].inc) % 4;
      chk($sformatf("table_speed_%0d", k), {30'd0, bus.SPEED}, exp_speed);
    end

    // Randomized key activity against the model
    do_reset();
    while (cyc < 600) begin
      logic k;
      int   len;
      k   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) step_cyc(k);
    end
    for (int i = 0; i < 12; i++) step_cyc(1'b1);

    // Asynchronous reset in mid-count at SPEED=2
    for (int i = 0; i < 8; i++) if (m_speed != 2) pulse(10, 10);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        step_cyc(1'b1);
        if (m_speed == 2 && m_cnt == 1) found = 1;
      end
    end
    chk("midrst_reached_state", {31'd0, found}, 1);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("midrst_clk_mux", {31'd0, bus.CLK_MUX}, 0);
    chk("midrst_speed",   {30'd0, bus.SPEED},   0);
    chk("midrst_step",    {31'd0, bus.STEP},    0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0;
    rise_e = 0;
    for (int e = 1; e <= 20; e++) begin
      step_cyc(1'b1);
      if (rise_e == 0 && bus.CLK_MUX === 1'b1) rise_e = e;
    end
    chk("midrst_first_rise", rise_e, DIV0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
